mux_rr_scheduler: RTL and testbench

//   Round-robin scheduler that shares one INS:1 bit mux between INS requesters.
//   - Drives the mux select s and a one-hot grant vector.
//   - Sits directly in front of the generic 1-bit mux; s connects to its select.
//   - Guarantees s is stable for the whole of each grant.
//

---
 rtl/mux_rr_scheduler_if.sv | 29 ++
 rtl/mux_rr_scheduler.sv | 149 ++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_rr_scheduler_if.sv
// Request/grant bundle between INS requesters and the mux scheduler.
// master = requester side (drives req), slave = scheduler (drives grant and select).
interface mux_rr_scheduler_if #(
   parameter int INS = 5
);
   localparam int SW = (INS > 1) ? $clog2(INS) : 1;

   logic [INS-1:0] req;
   logic [INS-1:0] gnt;
   logic [SW-1:0]  s;
   logic           busy;
   logic           preempt;

   modport master (
      output req,
      input  gnt,
      input  s,
      input  busy,
      input  preempt
   );

   modport slave (
      input  req,
      output gnt,
      output s,
      output busy,
      output preempt
   );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of a shared INS:1 bit mux; 1 clk req->gnt, no backpressure (owner holds req).
// Optional timeout pre-emption is built only when MUX_SCHED_TIMEOUT_EN is defined.
module mux_rr_scheduler #(
   parameter int INS     = 5,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   mux_rr_scheduler_if.slave bus
);
   localparam int SW = (INS > 1) ? $clog2(INS) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   if (INS < 2 || INS > 32) begin : g_bad_ins
      $error("mux_rr_scheduler: INS must be in 2..32");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mux_rr_scheduler: TIMEOUT must be in 1..255");
   end

   logic [0:0]     state_q, state_d;
   logic [INS-1:0] gnt_q, gnt_d;
   logic [SW-1:0]  s_q, s_d;
   logic [SW-1:0]  ptr_q, ptr_d;

   logic [INS-1:0] req_mask;
   logic [SW-1:0]  pick_base;
   logic [SW-1:0]  pick_idx;
   logic           pick_vld;
   logic [SW:0]    cand;
   logic [SW-1:0]  s_inc;
   logic           own_req;
   logic           timeout_hit;
   logic           new_grant;

   assign own_req  = bus.req[s_q];
   assign s_inc    = (s_q == SW'(INS - 1)) ? '0 : s_q + SW'(1);
   // The current owner never competes in the pick: on release its req is already low,
   // on pre-emption it must lose to any other requester.
   assign req_mask = bus.req & ~gnt_q;
   assign pick_base = (state_q == ST_GRANT) ? s_inc : ptr_q;

   // Descending scan so the smallest offset from pick_base is the one that sticks.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = INS - 1; i >= 0; i--) begin
         cand = {1'b0, pick_base} + (SW + 1)'(i);
         if (cand >= (SW + 1)'(INS)) begin
            cand = cand - (SW + 1)'(INS);
         end
         if (req_mask[cand[SW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[SW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      s_d       = s_q;
      ptr_d     = ptr_q;
      new_grant = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               new_grant = 1'b1;
            end
         end
         default: begin
            if (!own_req) begin
               ptr_d = s_inc;
               if (pick_vld) begin
                  new_grant = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = '0;
               end
            end else if (timeout_hit && pick_vld) begin
               ptr_d     = s_inc;
               new_grant = 1'b1;
            end
         end
      endcase
      // s and gnt move together in one edge, so a hand-off is one-hot to one-hot.
      if (new_grant) begin
         state_d = ST_GRANT;
         s_d     = pick_idx;
         gnt_d   = INS'(1) << pick_idx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         s_q     <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         s_q     <= s_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef MUX_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          preempt_q, preempt_d;

   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
   assign preempt_d   = (state_q == ST_GRANT) && own_req && timeout_hit && pick_vld;

   always_comb begin
      cnt_d = cnt_q;
      if (new_grant) begin
         cnt_d = '0;
      end else if ((state_q == ST_GRANT) && (cnt_q != CW'(TIMEOUT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         preempt_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
      end
   end

   assign bus.preempt = preempt_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.preempt = 1'b0;
`endif

   assign bus.gnt  = gnt_q;
   assign bus.s    = s_q;
   assign bus.busy = |gnt_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed + random bench for mux_rr_scheduler (INS=5, TIMEOUT=4) with a cycle model scoreboard.
// Build with or without MUX_SCHED_TIMEOUT_EN; expectations follow the same macro.
module tb_mux_rr_scheduler;
   localparam int INS = 5;
   localparam int TO  = 4;

   typedef struct packed {
      logic [4:0] gnt;
      logic [2:0] s;
      logic       busy;
      logic       pre;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mux_rr_scheduler_if #(.INS(INS)) bus ();

   mux_rr_scheduler #(.INS(INS), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t sb_q[$];

   bit m_act;
   int m_s;
   int m_ptr;
   int m_cnt;
   bit m_pre;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int rr_pick(input logic [4:0] mask, input int base);
      for (int off = 0; off < INS; off++) begin
         if (mask[(base + off) % INS]) return (base + off) % INS;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_act = 1'b0;
      m_s   = 0;
      m_ptr = 0;
      m_cnt = 0;
      m_pre = 1'b0;
      sb_q.delete();
   endtask

   // Reference behaviour for one clock edge given the req vector seen at that edge.
   task automatic model_step(input logic [4:0] r);
      int         k;
      logic [4:0] others;
      m_pre = 1'b0;
      if (!m_act) begin
         k = rr_pick(r, m_ptr);
         if (k >= 0) begin
            m_act = 1'b1;
            m_s   = k;
            m_cnt = 0;
         end
      end else begin
         others       = r;
         others[m_s]  = 1'b0;
         if (!r[m_s]) begin
            m_ptr = (m_s + 1) % INS;
            k     = rr_pick(others, m_ptr);
            if (k >= 0) begin
               m_s   = k;
               m_cnt = 0;
            end else begin
               m_act = 1'b0;
            end
         end
`ifdef MUX_SCHED_TIMEOUT_EN
         else if (m_cnt == TO - 1 && others != 5'b0) begin
            m_ptr = (m_s + 1) % INS;
            m_s   = rr_pick(others, m_ptr);
            m_cnt = 0;
            m_pre = 1'b1;
         end
`endif
         else if (m_cnt < TO) begin
            m_cnt++;
         end
      end
   endtask

   function automatic exp_t model_exp();
      exp_t e;
      e.gnt  = m_act ? 5'(1 << m_s) : 5'b0;
      e.s    = 3'(m_s);
      e.busy = m_act;
      e.pre  = m_pre;
      return e;
   endfunction

   task automatic cycle(input logic [4:0] r);
      exp_t got;
      exp_t want;
      bus.req = r;
      model_step(r);
      sb_q.push_back(model_exp());
      @(posedge clk);
      #1;
      got  = {bus.gnt, bus.s, bus.busy, bus.preempt};
      want = sb_q.pop_front();
      chk("sb", 32'(got), 32'(want));
   endtask

   task automatic do_reset();
      bus.req = 5'b0;
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   logic [4:0] r;
   logic [4:0] prev_gnt;
   int         use_c[INS];
   int         lim[INS];
   bit         waiting[INS];
   int         wait_g[INS];
   logic [2:0] exp_s;
   logic       exp_pre;

   initial begin
      do_reset();
      chk("rst_gnt", bus.gnt, 5'b0);
      chk("rst_s", bus.s, 3'd0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_pre", bus.preempt, 1'b0);

      // Move ptr off zero, then reset in the middle of a grant to input 2.
      cycle(5'b01000);
      chk("t1_g3", bus.gnt, 5'b01000);
      cycle(5'b00000);
      cycle(5'b00100);
      chk("t1_g2", bus.gnt, 5'b00100);
      chk("t1_s2", bus.s, 3'd2);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_async_gnt", bus.gnt, 5'b0);
      chk("t1_async_s", bus.s, 3'd0);
      chk("t1_async_busy", bus.busy, 1'b0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      cycle(5'b10001);
      chk("t1_ptr0", bus.gnt, 5'b00001);
      cycle(5'b00000);
      cycle(5'b00000);
      do_reset();
      cycle(5'b00100);
      chk("t1_regrant", bus.gnt, 5'b00100);

      // Three holders, each keeps the mux for two cycles, then 4 hands off to 0.
      do_reset();
      cycle(5'b10110);
      chk("t2_s1", bus.s, 3'd1);
      cycle(5'b10110);
      chk("t2_g1", bus.gnt, 5'b00010);
      cycle(5'b10100);
      chk("t2_s2", bus.s, 3'd2);
      chk("t2_busy2", bus.busy, 1'b1);
      cycle(5'b10100);
      cycle(5'b10000);
      chk("t2_s4", bus.s, 3'd4);
      chk("t2_g4", bus.gnt, 5'b10000);
      cycle(5'b10000);
      cycle(5'b00001);
      chk("t3_wrap_s", bus.s, 3'd0);
      chk("t3_wrap_g", bus.gnt, 5'b00001);
      chk("t3_busy", bus.busy, 1'b1);
      cycle(5'b00000);
      chk("t3_idle", bus.gnt, 5'b0);

      cycle(5'b01000);
      chk("t4_g3", bus.gnt, 5'b01000);
      cycle(5'b00000);
      chk("t4_idle_g", bus.gnt, 5'b0);
      chk("t4_idle_s", bus.s, 3'd3);
      chk("t4_idle_busy", bus.busy, 1'b0);
      cycle(5'b00000);
      chk("t4_keep_s", bus.s, 3'd3);

      do_reset();
      for (int k = 1; k <= 10; k++) begin
         cycle(5'b00101);
`ifdef MUX_SCHED_TIMEOUT_EN
         exp_s   = (k <= 4) ? 3'd0 : ((k <= 8) ? 3'd2 : 3'd0);
         exp_pre = (k == 5 || k == 9);
`else
         exp_s   = 3'd0;
         exp_pre = 1'b0;
`endif
         chk("t5_s", bus.s, exp_s);
         chk("t5_pre", bus.preempt, exp_pre);
      end
      cycle(5'b00000);

      // Random holders: raise, wait, use the mux 1..6 cycles, drop.
      do_reset();
      r        = 5'b0;
      prev_gnt = 5'b0;
      for (int i = 0; i < INS; i++) begin
         use_c[i]   = 0;
         lim[i]     = 1;
         waiting[i] = 1'b0;
         wait_g[i]  = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int i = 0; i < INS; i++) begin
            if (!r[i]) begin
               if ($urandom_range(2) == 0) begin
                  r[i]     = 1'b1;
                  lim[i]   = $urandom_range(6, 1);
                  use_c[i] = 0;
               end
            end else if (bus.gnt[i]) begin
               use_c[i]++;
               if (use_c[i] >= lim[i]) r[i] = 1'b0;
            end
            if (!r[i]) begin
               waiting[i] = 1'b0;
            end else if (!bus.gnt[i] && !waiting[i]) begin
               waiting[i] = 1'b1;
               wait_g[i]  = 0;
            end
         end
         cycle(r);
         chk("onehot", 32'($onehot0(bus.gnt)), 32'd1);
         if (bus.gnt != 5'b0) begin
            chk("s_idx", bus.gnt, 5'(1) << bus.s);
         end
         if (bus.gnt != 5'b0 && bus.gnt != prev_gnt) begin
            for (int i = 0; i < INS; i++) begin
               if (bus.gnt[i]) begin
                  if (waiting[i]) chk("fair", 32'(wait_g[i] < INS), 32'd1);
                  waiting[i] = 1'b0;
               end else if (waiting[i]) begin
                  wait_g[i]++;
               end
            end
         end
         prev_gnt = bus.gnt;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
